// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed 7-segment display scanner. A prescaler divides clk down
//   to one digit slot of SCAN_DIV cycles. Each slot drives one digit, and
//   N_DIGITS slots make one frame. New display contents are captured into a
//   shadow bank on `load`. They are promoted to the active bank only at a
//   frame wrap, so a frame never mixes old and new digits.
//
// Parameters
//   N_DIGITS    number of digits scanned (2..16)
//   SCAN_DIV    clock cycles each digit is held (>= 2)
//   HEX_EN      1: codes 10-15 render A-F; 0: codes 10-15 render a dash
//   SEG_ACT_LOW 1: seg_out pins inverted
//   DIG_ACT_LOW 1: dig_sel pins inverted
//
// Ports
//   clk         clock; all state changes on the rising edge
//   rst_n       synchronous, active-low reset
//   load        one-cycle strobe; captures value/dp_mask/blank_mask/lz_en
//   value       4-bit digit codes; nibble k is digit k (digit 0 = LSD)
//   dp_mask     bit k lights the decimal point of digit k
//   blank_mask  bit k forces digit k fully dark, dp included
//   lz_en       leading-zero suppression enable
//   seg_out     registered segments {a,b,c,d,e,f,g,dp}
//   dig_sel     registered one-hot digit enable, bit k = digit k
//   frame_done  one-cycle pulse when the scan wraps back to digit 0
module seg_scan_driver #(
    parameter int N_DIGITS    = 8,
    parameter int SCAN_DIV    = 100000,
    parameter int HEX_EN      = 1,
    parameter int SEG_ACT_LOW = 0,
    parameter int DIG_ACT_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp_mask,
    input  logic [N_DIGITS-1:0]     blank_mask,
    input  logic                    lz_en,
    output logic [7:0]              seg_out,
    output logic [N_DIGITS-1:0]     dig_sel,
    output logic                    frame_done
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    // Segment pattern for a 4-bit code, active-high, dp bit left clear.
    function automatic logic [7:0] glyph(input logic [3:0] code);
        logic [7:0] g;
        case (code)
            4'h0:    g = 8'hFC;
            4'h1:    g = 8'h60;
            4'h2:    g = 8'hDA;
            4'h3:    g = 8'hF2;
            4'h4:    g = 8'h66;
            4'h5:    g = 8'hB6;
            4'h6:    g = 8'hBE;
            4'h7:    g = 8'hE0;
            4'h8:    g = 8'hFE;
            4'h9:    g = 8'hE6;
            4'hA:    g = 8'hEE;
            4'hB:    g = 8'h3E;
            4'hC:    g = 8'h9C;
            4'hD:    g = 8'h7A;
            4'hE:    g = 8'h9E;
            default: g = 8'h8E;
        endcase
        if ((HEX_EN == 0) && (code >= 4'hA)) begin
            g = 8'h02;
        end
        return g;
    endfunction

    // ---------------- stage 0: scan timing and register banks ----------------
    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic                    tc;
    logic                    wrap;

    logic [4*N_DIGITS-1:0]   sh_value;
    logic [N_DIGITS-1:0]     sh_dp;
    logic [N_DIGITS-1:0]     sh_blank;
    logic                    sh_lz;
    logic                    pending;

    logic [4*N_DIGITS-1:0]   act_value;
    logic [N_DIGITS-1:0]     act_dp;
    logic [N_DIGITS-1:0]     act_blank;
    logic                    act_lz;

    always_comb begin
        tc   = (presc == PRESC_LAST);
        wrap = tc && (idx == IDX_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (tc) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A load landing exactly on the wrap goes straight to the active bank so
    // the new contents show in the frame that is just starting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_value  <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            sh_lz     <= 1'b0;
            pending   <= 1'b0;
            act_value <= '0;
            act_dp    <= '0;
            act_blank <= '0;
            act_lz    <= 1'b0;
        end else if (load && wrap) begin
            sh_value  <= value;
            sh_dp     <= dp_mask;
            sh_blank  <= blank_mask;
            sh_lz     <= lz_en;
            pending   <= 1'b0;
            act_value <= value;
            act_dp    <= dp_mask;
            act_blank <= blank_mask;
            act_lz    <= lz_en;
        end else if (load) begin
            sh_value  <= value;
            sh_dp     <= dp_mask;
            sh_blank  <= blank_mask;
            sh_lz     <= lz_en;
            pending   <= 1'b1;
        end else if (wrap && pending) begin
            act_value <= sh_value;
            act_dp    <= sh_dp;
            act_blank <= sh_blank;
            act_lz    <= sh_lz;
            pending   <= 1'b0;
        end
    end

    // Leading-zero mask: digit k is dark when it and every digit above it are
    // zero. The running AND walks down from the MSD; digit 0 is never masked.
    logic [N_DIGITS-1:0] supp;
    logic                run;
    logic [3:0]          cur_code;
    logic                cur_dp;
    logic                cur_dark;
    logic [7:0]          seg_next;
    logic [N_DIGITS-1:0] dig_next;

    always_comb begin
        supp = '0;
        run  = act_lz;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            run     = run && (act_value[4*k +: 4] == 4'd0);
            supp[k] = run;
        end

        cur_code = 4'd0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        dig_next = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_code    = act_value[4*k +: 4];
                cur_dp      = act_dp[k];
                cur_dark    = act_blank[k] || supp[k];
                dig_next[k] = 1'b1;
            end
        end

        seg_next = cur_dark ? 8'h00 : (glyph(cur_code) | {7'b0, cur_dp});
    end

    // ---------------- stage 1: registered outputs ----------------
    logic [7:0]          seg_p1;
    logic [N_DIGITS-1:0] dig_p1;
    logic                frame_done_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_p1        <= '0;
            dig_p1        <= '0;
            frame_done_p1 <= 1'b0;
        end else begin
            seg_p1        <= seg_next;
            dig_p1        <= dig_next;
            frame_done_p1 <= wrap;
        end
    end

    // Pin polarity is applied on the flop outputs only.
    assign seg_out    = (SEG_ACT_LOW != 0) ? ~seg_p1 : seg_p1;
    assign dig_sel    = (DIG_ACT_LOW != 0) ? ~dig_p1 : dig_p1;
    assign frame_done = frame_done_p1;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_mask = 4'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic        lz_en = 1'b0;

    logic [7:0]  seg_a, seg_b;
    logic [3:0]  dig_a, dig_b;
    logic        fd_a, fd_b;

    logic [7:0]  dig_a8, dig_b8, fd_a8, fd_b8;
    assign dig_a8 = {4'b0, dig_a};
    assign dig_b8 = {4'b0, dig_b};
    assign fd_a8  = {7'b0, fd_a};
    assign fd_b8  = {7'b0, fd_b};

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    seg_scan_driver #(
        .N_DIGITS(4), .SCAN_DIV(4), .HEX_EN(1), .SEG_ACT_LOW(0), .DIG_ACT_LOW(0)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .dp_mask(dp_mask), .blank_mask(blank_mask), .lz_en(lz_en),
        .seg_out(seg_a), .dig_sel(dig_a), .frame_done(fd_a)
    );

    // Dash rendering and inverted pins on a second build sharing the inputs.
    seg_scan_driver #(
        .N_DIGITS(4), .SCAN_DIV(4), .HEX_EN(0), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .dp_mask(dp_mask), .blank_mask(blank_mask), .lz_en(lz_en),
        .seg_out(seg_b), .dig_sel(dig_b), .frame_done(fd_b)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int j);
        while (cyc < j) tick();
    endtask

    // Present a load so it is sampled at edge number `at`.
    task automatic do_load(input int at, input logic [15:0] v, input logic [3:0] dp,
                           input logic [3:0] bl, input logic lz);
        run_to(at - 1);
        value      = v;
        dp_mask    = dp;
        blank_mask = bl;
        lz_en      = lz;
        load       = 1'b1;
        tick();
        load       = 1'b0;
    endtask

    task automatic expect_a(input string tag, input int j, input logic [7:0] seg,
                            input logic [7:0] dig);
        run_to(j);
        chk({tag, "_seg"}, seg_a, seg);
        chk({tag, "_dig"}, dig_a8, dig);
    endtask

    int n60;

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_seg_a", seg_a, 8'h00);
        chk("rst_dig_a", dig_a8, 8'h00);
        chk("rst_fd_a", fd_a8, 8'h00);
        chk("rst_seg_b", seg_b, 8'hFF);
        chk("rst_dig_b", dig_b8, 8'h0F);
        chk("rst_fd_b", fd_b8, 8'h00);
        rst_n = 1'b1;
        cyc = 0;

        // Idle scan: FC on every digit, walking one-hot select
        expect_a("idle_d0", 1, 8'hFC, 8'h01);
        chk("idle_fd_e1", fd_a8, 8'h00);
        expect_a("idle_d1", 5, 8'hFC, 8'h02);
        expect_a("idle_d2", 9, 8'hFC, 8'h04);
        chk("idle_dig_b", dig_b8, 8'h0B);
        expect_a("idle_d3", 13, 8'hFC, 8'h08);
        run_to(15);
        chk("fd_e15", fd_a8, 8'h00);
        run_to(16);
        chk("fd_e16", fd_a8, 8'h01);
        chk("fd_b_e16", fd_b8, 8'h01);
        chk("dig_e16", dig_a8, 8'h08);
        run_to(17);
        chk("fd_e17", fd_a8, 8'h00);
        chk("dig_e17", dig_a8, 8'h01);
        run_to(32);
        chk("fd_e32", fd_a8, 8'h01);

        // Mid-frame load: old digits hold until the wrap
        do_load(40, 16'h12AF, 4'b0010, 4'b0000, 1'b0);
        expect_a("mid_old", 41, 8'hFC, 8'h04);
        expect_a("mid_last", 48, 8'hFC, 8'h08);
        expect_a("mid_d0", 49, 8'h8E, 8'h01);
        expect_a("mid_d1", 53, 8'hEF, 8'h02);
        expect_a("mid_d2", 57, 8'hDA, 8'h04);
        expect_a("mid_d3", 61, 8'h60, 8'h08);

        // Leading-zero suppression
        do_load(70, 16'h0050, 4'b0000, 4'b0000, 1'b1);
        expect_a("lz_d0", 81, 8'hFC, 8'h01);
        expect_a("lz_d1", 85, 8'hB6, 8'h02);
        expect_a("lz_d2", 89, 8'h00, 8'h04);
        expect_a("lz_d3", 93, 8'h00, 8'h08);
        do_load(100, 16'h0000, 4'b0000, 4'b0000, 1'b1);
        expect_a("lz0_d0", 113, 8'hFC, 8'h01);
        expect_a("lz0_d1", 117, 8'h00, 8'h02);
        expect_a("lz0_d2", 121, 8'h00, 8'h04);
        expect_a("lz0_d3", 125, 8'h00, 8'h08);

        // Two loads in one frame: last one wins
        do_load(134, 16'h1111, 4'b0000, 4'b0000, 1'b0);
        do_load(138, 16'h2222, 4'b0000, 4'b0000, 1'b0);
        n60 = 0;
        for (int j = 145; j <= 160; j++) begin
            run_to(j);
            if (seg_a == 8'h60) n60++;
            if (((j - 145) % 4) == 0) chk("dbl_seg", seg_a, 8'hDA);
        end
        chk("dbl_no60", 8'(n60), 8'h00);

        // Load coincident with the frame wrap takes effect immediately
        do_load(176, 16'h3333, 4'b0000, 4'b0000, 1'b0);
        chk("wrap_prev_seg", seg_a, 8'hDA);
        chk("wrap_fd", fd_a8, 8'h01);
        expect_a("wrap_d0", 177, 8'hF2, 8'h01);
        expect_a("wrap_d3", 189, 8'hF2, 8'h08);

        // Blanking clears dp; dash rendering and inverted pins on build B
        do_load(200, 16'h4B08, 4'b0011, 4'b0001, 1'b0);
        expect_a("blk_d0", 209, 8'h00, 8'h01);
        chk("blk_b_d0", seg_b, 8'hFF);
        expect_a("blk_d1", 213, 8'hFD, 8'h02);
        expect_a("blk_d2", 217, 8'h3E, 8'h04);
        chk("dash_b_seg", seg_b, 8'hFD);
        chk("dash_b_dig", dig_b8, 8'h0B);
        expect_a("blk_d3", 221, 8'h66, 8'h08);

        // Reset with a load pending; load during reset is ignored
        do_load(232, 16'h7777, 4'b0000, 4'b0000, 1'b0);
        run_to(234);
        rst_n = 1'b0;
        value = 16'h9999;
        load  = 1'b1;
        repeat (3) tick();
        chk("rst2_seg", seg_a, 8'h00);
        chk("rst2_dig", dig_a8, 8'h00);
        chk("rst2_fd", fd_a8, 8'h00);
        load  = 1'b0;
        rst_n = 1'b1;
        cyc = 0;
        expect_a("post_d0", 1, 8'hFC, 8'h01);
        expect_a("post_d3", 13, 8'hFC, 8'h08);
        expect_a("post_f1_d0", 17, 8'hFC, 8'h01);
        expect_a("post_f1_d1", 21, 8'hFC, 8'h02);
        expect_a("post_f1_d2", 25, 8'hFC, 8'h04);
        expect_a("post_f1_d3", 29, 8'hFC, 8'h08);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8, number of time-multiplexed digits (2..16).
REQ-002 SHALL have parameter SCAN_DIV, default 100000, clock cycles each digit is held (>=2).
REQ-003 SHALL have parameter HEX_EN, default 1; 1 = codes 10-15 render A-F, 0 = codes 10-15 render dash.
REQ-004 SHALL have parameter SEG_ACT_LOW, default 0; 1 = seg_out inverted at output.
REQ-005 SHALL have parameter DIG_ACT_LOW, default 1; 1 = dig_sel inverted at output.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 load  input  1  one-cycle strobe; capture value/dp_mask/blank_mask/lz_en.
REQ-009 value  input  4*N_DIGITS  digit codes; nibble k = digit k, digit 0 least significant.
REQ-010 dp_mask  input  N_DIGITS  bit k lights decimal point of digit k.
REQ-011 blank_mask  input  N_DIGITS  bit k forces digit k fully dark, dp included.
REQ-012 lz_en  input  1  leading-zero suppression enable.
REQ-013 seg_out  output  8  registered segments {a,b,c,d,e,f,g,dp}, bit7=a, bit0=dp, 1 = lit before polarity.
REQ-014 dig_sel  output  N_DIGITS  registered one-hot digit enable, bit k = digit k, before polarity.
REQ-015 frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-016 SHALL use a prescaler counting 0..SCAN_DIV-1; terminal count (tc) at SCAN_DIV-1, then wraps to 0.
REQ-017 SHALL advance digit index idx on tc: 0,1,..,N_DIGITS-1, then wraps to 0 (frame wrap).
REQ-018 SHALL hold two register sets: shadow (written by load) and active (drives display), plus a pending flag.
REQ-019 load not coincident with frame wrap: shadow <= inputs, pending <= 1; repeated loads: last one wins.
REQ-020 Frame wrap, no load same cycle: if pending, active <= shadow, pending <= 0.
REQ-021 load coincident with frame wrap: active <= inputs directly, pending <= 0, shadow <= inputs.
REQ-022 Active set SHALL never change mid-frame (no tearing).
REQ-023 frame_done SHALL be 1 exactly in the cycle after the wrapping tc edge, i.e. with idx = 0 newly registered.
REQ-024 Glyphs, active-high: 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0 8=FE 9=E6.
REQ-025 HEX_EN=1: A=EE b=3E C=9C d=7A E=9E F=8E; HEX_EN=0: codes 10-15 = 02 (g only).
REQ-026 Leading zero: with lz_en=1, digit k is dark when its code and all codes above k are 0; digit 0 is never suppressed.
REQ-027 dp bit SHALL be OR-ed after glyph lookup, but cleared when digit is blanked (blank_mask) or suppressed.
REQ-028 seg_out/dig_sel SHALL reflect (idx, active) of the previous cycle: one cycle registered latency.
REQ-029 dig_sel SHALL be one-hot (pre-polarity) at all times after the first post-reset cycle; all-zero only in reset.
REQ-030 Polarity inversion SHALL be applied after the register, combinationally on the flop output only.

Reset
REQ-031 rst_n=0 at an edge: prescaler=0, idx=0, pending=0, shadow and active all zero, lz_en latched 0.
REQ-032 In reset: seg_out pre-polarity 00 (pins 00 if SEG_ACT_LOW=0, FF if 1); dig_sel pre-polarity 0 (pins all-1 if DIG_ACT_LOW=1); frame_done=0.
REQ-033 Reset mid-frame SHALL discard any pending load; load asserted with rst_n=0 is ignored.
REQ-034 First cycle after release: seg_out=FC, dig_sel=digit 0 (active value 0, no suppression).

Verification (N_DIGITS=4, SCAN_DIV=4, HEX_EN=1, SEG_ACT_LOW=0, DIG_ACT_LOW=0)
REQ-035 Release reset, no load -> digits 0..3 each show FC for 4 cycles, dig_sel 0001,0010,0100,1000; frame_done every 16 cycles.
REQ-036 load value=16'h12AF, dp_mask=0010, mid-frame -> old digits until wrap; next frame: digit0=8E, digit1=EE|01=EF, digit2=DA, digit3=60.
REQ-037 value=16'h0050, lz_en=1 -> digit3 and digit2 dark (00), digit1=B6, digit0=FC; value=16'h0000 -> only digit0=FC lit.
REQ-038 Two loads in one frame (16'h1111 then 16'h2222) -> next frame shows DA on all digits; 60 never appears.
REQ-039 load 16'h3333 in the same cycle as frame wrap -> F2 on digit0 in that very frame; no one-frame delay.
REQ-040 Reset pulsed with a load pending -> post-reset display FC on all digits; HEX_EN=0 build with code 4'hB -> 02.
